// File: rtl/wishbone_slave_router.sv
// Single-master to four-slave Wishbone router: address-decoded fan-out with one
// outstanding transaction, bus error on disabled slaves and on response timeout.
module wishbone_slave_router #(
   parameter logic [3:0]  SLAVE_ENABLE   = 4'b1111,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_data_i,
   input  logic [23:0]   wb_adr_i,
   output logic          wb_ack_o,
   output logic          wb_stall_o,
   output logic          wb_error_o,
   output logic [31:0]   wb_data_o,
   output logic [3:0]    slave_cyc_o,
   output logic [3:0]    slave_stb_o,
   output logic          slave_we_o,
   output logic [3:0]    slave_sel_o,
   output logic [31:0]   slave_data_o,
   output logic [23:0]   slave_adr_o,
   input  logic [3:0]    slave_ack_i,
   input  logic [3:0]    slave_stall_i,
   input  logic [3:0]    slave_error_i,
   input  logic [127:0]  slave_data_i,
   output logic [1:0]    probe_currentSlave,
   output logic [1:0]    probe_state
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t            state;
   logic [1:0]        cur;
   logic [CNT_W-1:0]  cnt;

   logic [1:0]        idx;
   logic              idx_en;
   logic              accept;
   logic              cur_ack;
   logic              cur_err;
   logic              resp;
   logic [31:0]       rd_words [4];

   assign slave_we_o   = wb_we_i;
   assign slave_sel_o  = wb_sel_i;
   assign slave_data_o = wb_data_i;
   assign slave_adr_o  = wb_adr_i;

   assign idx     = wb_adr_i[23:22];
   assign idx_en  = SLAVE_ENABLE[idx];
   assign cur_ack = slave_ack_i[cur];
   assign cur_err = slave_error_i[cur];
   assign resp    = cur_ack | cur_err;

   for (genvar n = 0; n < 4; n++) begin : g_rd
      assign rd_words[n] = slave_data_i[32*n +: 32];
   end

   // Master-facing response and slave strobes are combinational so the
   // response reaches the master in the cycle it arrives; held low in reset.
   always_comb begin
      slave_cyc_o = '0;
      slave_stb_o = '0;
      wb_stall_o  = 1'b0;
      wb_ack_o    = 1'b0;
      wb_error_o  = 1'b0;
      wb_data_o   = '0;
      if (wb_rst_i) begin
         unique case (state)
            ST_IDLE: begin
               if (idx_en) begin
                  slave_cyc_o[idx] = wb_cyc_i;
                  slave_stb_o[idx] = wb_stb_i;
                  wb_stall_o       = slave_stall_i[idx];
               end
            end
            ST_BUSY: begin
               slave_cyc_o[cur] = wb_cyc_i;
               wb_stall_o       = 1'b1;
               wb_data_o        = rd_words[cur];
               wb_error_o       = cur_err & wb_cyc_i;
               wb_ack_o         = cur_ack & ~cur_err & wb_cyc_i;
            end
            ST_ERROR: begin
               wb_stall_o = 1'b1;
               wb_error_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;

   // Transaction tracking: latch the decoded slave and count silent BUSY cycles.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= ST_IDLE;
         cur   <= 2'd0;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (idx_en) begin
                     state <= ST_BUSY;
                     cur   <= idx;
                     cnt   <= '0;
                  end else begin
                     state <= ST_ERROR;
                  end
               end
            end
            ST_BUSY: begin
               if (!wb_cyc_i || resp) begin
                  state <= ST_IDLE;
               end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                  state <= ST_ERROR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ERROR: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign probe_currentSlave = cur;
   assign probe_state        = state;

endmodule

// File: doc/wishbone_slave_router.md
Name: wishbone_slave_router

Overview:
- Single Wishbone master port fanned out to four slave ports; the opposite direction of the multi-master/single-slave arbiter.
- Decodes wb_adr_i[23:22] to select a slave and tracks one outstanding transaction.
- Generates a bus error for disabled slaves and for slaves that never respond.
- Sits between a core/bridge master and the peripheral slaves.

Parameters:
- SLAVE_ENABLE, 4'b1111, bit n = 1 enables slave n. A disabled slave's address region returns error.
- TIMEOUT_CYCLES, 255, cycles in BUSY before error is forced. 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  master cycle.
- wb_stb_i  in  1  master strobe.
- wb_we_i  in  1  master write enable.
- wb_sel_i  in  4  master byte select.
- wb_data_i  in  32  master write data.
- wb_adr_i  in  24  master address.
- wb_ack_o  out  1  ack to master.
- wb_stall_o  out  1  stall to master.
- wb_error_o  out  1  error to master.
- wb_data_o  out  32  read data to master.
- slave_cyc_o  out  4  per-slave cycle.
- slave_stb_o  out  4  per-slave strobe.
- slave_we_o  out  1  shared write enable, equals wb_we_i.
- slave_sel_o  out  4  shared byte select, equals wb_sel_i.
- slave_data_o  out  32  shared write data, equals wb_data_i.
- slave_adr_o  out  24  shared address, equals wb_adr_i.
- slave_ack_i  in  4  per-slave ack.
- slave_stall_i  in  4  per-slave stall.
- slave_error_i  in  4  per-slave error.
- slave_data_i  in  128  read data; slave n on bits [32n+31:32n].
- probe_currentSlave  out  2  latched slave index.
- probe_state  out  2  FSM state: IDLE=0, BUSY=1, ERROR=2.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - state=IDLE, latched slave=0, counter=0.
  - wb_ack_o=0, wb_error_o=0, wb_data_o=0, wb_stall_o=0; slave_cyc_o=0, slave_stb_o=0; probes=0.
- Decode: idx = wb_adr_i[23:22]. Shared slave outputs are pure combinational pass-through.
- IDLE:
  - Enabled idx: slave_cyc_o[idx]=wb_cyc_i, slave_stb_o[idx]=wb_stb_i; wb_stall_o=slave_stall_i[idx].
  - Disabled idx: no slave strobed, wb_stall_o=0.
  - Accept = wb_cyc_i & wb_stb_i & !wb_stall_o.
  - Accept on enabled idx -> BUSY; latch idx, counter=0.
  - Accept on disabled idx -> ERROR.
  - All other slave bits are 0. wb_ack_o=wb_error_o=0; slave ack/error inputs are ignored.
- BUSY:
  - slave_cyc_o[latched]=wb_cyc_i; slave_stb_o=0; wb_stall_o=1.
  - wb_data_o = slave_data_i[latched]; wb_data_o=0 in every other state.
  - wb_error_o = slave_error_i[latched]; wb_ack_o = slave_ack_i[latched] & !slave_error_i[latched]. Error wins when both are set.
  - Ack or error -> IDLE next cycle; the response is seen by the master in the same cycle it arrives (zero added latency).
  - Counter increments each BUSY cycle without a response.
  - Counter == TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES>0) -> ERROR. A response on that cycle wins and the state goes to IDLE.
  - wb_cyc_i=0 -> IDLE next cycle; slave cyc drops combinationally; no ack/error is delivered; any late slave response is ignored.
- ERROR:
  - Lasts one cycle: wb_error_o=1, wb_stall_o=1, all slave cyc/stb=0, wb_ack_o=0; then -> IDLE.
- At most one outstanding transaction. Back-to-back strobes are stalled until return to IDLE.
- Minimum turnaround is 2 cycles per transfer (accept cycle + response cycle).
- A reset asserted mid-transaction drops all slave strobes immediately; no response is delivered.

Test Plan:
- Write adr=24'h400010, data=32'hDEADBEEF; slave1 acks 3 cycles later -> only slave_stb_o[1] pulses for 1 cycle; wb_ack_o=1 for exactly 1 cycle; state returns to 0.
- Read adr=24'hC00000; slave3 drives 32'h12345678 with ack -> wb_data_o=32'h12345678 in the ack cycle; probe_currentSlave=3.
- SLAVE_ENABLE=4'b0111, access adr=24'hC00004 -> no slave_stb_o; wb_error_o=1 exactly 1 cycle after accept.
- TIMEOUT_CYCLES=4, slave2 silent -> wb_error_o=1 on the 5th cycle after accept, slave_cyc_o[2] drops; slave ack at counter=3 instead -> wb_ack_o=1, no error.
- slave0 holds stall 2 cycles -> wb_stall_o=1 for those cycles, accept on the 3rd; wb_cyc_i deasserted while BUSY -> state IDLE next cycle, no ack forwarded.
- Assert wb_rst_i=0 while BUSY -> all outputs 0 asynchronously; first access after release decodes normally.
